// File: rtl/ysyx_22040895_ifu_pkg.sv
// Shared constants, FSM state encoding and buffer entry type for the
// instruction fetch unit (ysyx_22040895_ifu and its FIFO).
package ysyx_22040895_ifu_pkg;

   localparam logic [63:0] ysyx_22040895_RESET_PC = 64'h8000_0000;

   localparam int OpCodeLength = 7;
   localparam int func3Length  = 3;
   localparam int func7Length  = 7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DROP = 2'd3
   } ifu_state_e;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } ifu_entry_t;

endpackage

// File: rtl/ysyx_22040895_ifu_fifo.sv
// Instruction buffer: {pc,inst} FIFO with wrap-around pointers, sync flush.
// Ports: push_i/data_i, pop_i/data_o (head), empty_o, count_o, flush_i.
module ysyx_22040895_ifu_fifo
   import ysyx_22040895_ifu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  ifu_entry_t             data_i,
   input  logic                   pop_i,
   output ifu_entry_t             data_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   ifu_entry_t    mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [CW-1:0] cnt_q;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_q <= rd_q + 1'b1;
         end
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch: PC, imem req/rsp FSM, instruction buffer, redirect.
// Ports: redirect_*, imem_req_*, imem_rsp_*, inst_*/pc_o/opcode/func3/func7.
// Macro YSYX_22040895_IFU_MISALIGN_CHK_EN adds exc_misalign_o and blocks
// fetch after a misaligned redirect; otherwise target bits [1:0] are zeroed.
module ysyx_22040895_ifu
   import ysyx_22040895_ifu_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = ysyx_22040895_RESET_PC,
   parameter int          BUF_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    redirect_i,
   input  logic [63:0]             redirect_pc_i,
   output logic                    imem_req_valid_o,
   input  logic                    imem_req_ready_i,
   output logic [63:0]             imem_req_addr_o,
   input  logic                    imem_rsp_valid_i,
   input  logic [31:0]             imem_rsp_data_i,
   output logic                    inst_valid_o,
   input  logic                    inst_ready_i,
   output logic [31:0]             inst_o,
   output logic [63:0]             pc_o,
   output logic [OpCodeLength-1:0] opcode_o,
   output logic [func3Length-1:0]  func3_o,
   output logic [func7Length-1:0]  func7_o
`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
   ,
   output logic                    exc_misalign_o
`endif
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   ifu_state_e    state_q;
   logic [63:0]   pc_q;
   logic [63:0]   req_pc_q;
   logic [63:0]   addr_q;
   logic          req_valid_q;
   logic          misalign_q;

   logic [63:0]   tgt;
   logic          tgt_bad;
   logic          hs;
   logic          credit;
   logic          push;
   logic          pop;
   logic          empty;
   logic [CW-1:0] count;
   logic [CW-1:0] used;
   ifu_entry_t    head;
   ifu_entry_t    push_ent;

`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
   assign tgt     = redirect_pc_i;
   assign tgt_bad = |redirect_pc_i[1:0];
`else
   assign tgt     = {redirect_pc_i[63:2], 2'b00};
   assign tgt_bad = 1'b0;
`endif

   assign hs = req_valid_q & imem_req_ready_i;

   // Buffered entries plus the one in flight must leave room.
   assign used   = count + CW'(state_q == S_WAIT);
   assign credit = ~misalign_q & (used < CW'(BUF_DEPTH));

   assign push = (state_q == S_WAIT) & imem_rsp_valid_i & ~redirect_i;
   assign pop  = inst_valid_o & inst_ready_i;

   assign push_ent.pc   = req_pc_q;
   assign push_ent.inst = imem_rsp_data_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         req_pc_q    <= '0;
         addr_q      <= '0;
         req_valid_q <= 1'b0;
         misalign_q  <= 1'b0;
      end else if (redirect_i) begin
         pc_q       <= tgt;
         misalign_q <= tgt_bad;
         unique case (state_q)
            S_IDLE, S_REQ: begin
               if (hs) begin
                  // accepted request now belongs to the old path
                  state_q     <= S_DROP;
                  req_valid_q <= 1'b0;
               end else if (tgt_bad) begin
                  state_q     <= S_IDLE;
                  req_valid_q <= 1'b0;
               end else begin
                  state_q     <= S_REQ;
                  req_valid_q <= 1'b1;
                  addr_q      <= tgt;
               end
            end
            default: begin
               state_q     <= imem_rsp_valid_i ? S_IDLE : S_DROP;
               req_valid_q <= 1'b0;
            end
         endcase
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (credit) begin
                  state_q     <= S_REQ;
                  req_valid_q <= 1'b1;
                  addr_q      <= pc_q;
               end
            end
            S_REQ: begin
               if (hs) begin
                  req_pc_q    <= pc_q;
                  pc_q        <= pc_q + 64'd4;
                  state_q     <= S_WAIT;
                  req_valid_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid_i) begin
                  if (credit) begin
                     state_q     <= S_REQ;
                     req_valid_q <= 1'b1;
                     addr_q      <= pc_q;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_DROP: begin
               if (imem_rsp_valid_i) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   ysyx_22040895_ifu_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_i),
      .push_i  (push),
      .data_i  (push_ent),
      .pop_i   (pop),
      .data_o  (head),
      .empty_o (empty),
      .count_o (count)
   );

   assign imem_req_valid_o = req_valid_q;
   assign imem_req_addr_o  = addr_q;
   assign inst_valid_o     = ~empty;
   assign inst_o           = head.inst;
   assign pc_o             = head.pc;
   assign opcode_o         = head.inst[6:0];
   assign func3_o          = head.inst[14:12];
   assign func7_o          = head.inst[31:25];

`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
   assign exc_misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_ysyx_22040895_ifu.sv
// Randomized bench for ysyx_22040895_ifu: imem responder plus a
// stream-level model of expected fetch addresses and consumed pcs.
module tb_ysyx_22040895_ifu;

   localparam logic [63:0] RPC = 64'h8000_0000;
`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
   localparam logic [63:0] LOWMASK = 64'h0;
`else
   localparam logic [63:0] LOWMASK = 64'h3;
`endif

   logic        clk;
   logic        rst;
   logic        redirect_i;
   logic [63:0] redirect_pc_i;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [63:0] imem_req_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [63:0] pc_o;
   logic [6:0]  opcode_o;
   logic [2:0]  func3_o;
   logic [6:0]  func7_o;
`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
   logic        exc_misalign_o;
`endif

   ysyx_22040895_ifu dut (
      .clk              (clk),
      .rst              (rst),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .inst_valid_o     (inst_valid_o),
      .inst_ready_i     (inst_ready_i),
      .inst_o           (inst_o),
      .pc_o             (pc_o),
      .opcode_o         (opcode_o),
      .func3_o          (func3_o),
      .func7_o          (func7_o)
`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
      ,
      .exc_misalign_o   (exc_misalign_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk;
   int          n_pass;
   int          cyc;
   int          n_cons;
   bit          last_rsp;
   bit          last_acc;
   logic [63:0] last_cons_pc;
   logic [63:0] exp_pc;
   logic [63:0] fetch_ptr;
   logic [63:0] q_addr [$];
   int          q_due [$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   function automatic logic [31:0] memf(input logic [63:0] a);
      return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
   endfunction

   task automatic model_reset();
      q_addr.delete();
      q_due.delete();
      exp_pc    = RPC;
      fetch_ptr = RPC;
   endtask

   // One cycle: drive at negedge, account for what the next posedge does.
   task automatic step(input bit rd, input logic [63:0] tg, input bit rdy,
                       input bit ir, input int dly);
      logic [63:0] t;
      logic [31:0] w;
      redirect_i       = rd;
      redirect_pc_i    = tg;
      imem_req_ready_i = rdy;
      inst_ready_i     = ir;
      last_rsp = 1'b0;
      last_acc = 1'b0;
      if (q_addr.size() > 0 && cyc >= q_due[0]) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = memf(q_addr[0]);
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
         last_rsp = 1'b1;
      end else begin
         imem_rsp_valid_i = 1'b0;
         imem_rsp_data_i  = $urandom;
      end
      if (inst_valid_o && ir) begin
         w = memf(exp_pc);
         chk("pc", pc_o, exp_pc);
         chk("inst", 64'(inst_o), 64'(w));
         chk("opcode", 64'(opcode_o), 64'(w[6:0]));
         chk("func3", 64'(func3_o), 64'(w[14:12]));
         chk("func7", 64'(func7_o), 64'(w[31:25]));
         n_cons++;
         last_cons_pc = pc_o;
         exp_pc = exp_pc + 64'd4;
      end
      if (imem_req_valid_o && rdy) begin
         chk("req_addr", imem_req_addr_o, fetch_ptr);
         q_addr.push_back(imem_req_addr_o);
         q_due.push_back(cyc + 1 + dly);
         fetch_ptr = fetch_ptr + 64'd4;
         last_acc = 1'b1;
      end
      if (rd) begin
         t = tg & ~LOWMASK;
         exp_pc    = t;
         fetch_ptr = t;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_until_cons(input string tag, input logic [63:0] want);
      int c0;
      c0 = n_cons;
      for (int k = 0; k < 40; k++) begin
         if (n_cons == c0) step(1'b0, '0, 1'b1, 1'b1, 0);
      end
      chk({tag, "_progress"}, 64'(n_cons > c0), 64'd1);
      chk({tag, "_first_pc"}, last_cons_pc, want);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_req_valid"}, 64'(imem_req_valid_o), 64'd0);
      chk({tag, "_addr"}, imem_req_addr_o, 64'd0);
      chk({tag, "_inst_valid"}, 64'(inst_valid_o), 64'd0);
      chk({tag, "_inst"}, 64'(inst_o), 64'd0);
      chk({tag, "_pc"}, pc_o, 64'd0);
   endtask

   bit          rd;
   logic [63:0] tg;
   bit          seen;

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0; n_cons = 0;
      last_cons_pc = '0;
      rst = 1'b0;
      redirect_i = 1'b0; redirect_pc_i = '0;
      imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i = '0; inst_ready_i = 1'b0;
      model_reset();

      // reset, first request one cycle after release
      repeat (3) @(negedge clk);
      chk_reset_outs("rst0");
      rst = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0, 0);
      chk("t1_req_valid", 64'(imem_req_valid_o), 64'd1);
      chk("t1_req_addr", imem_req_addr_o, RPC);

      // back-to-back fetch, rsp one cycle after accept
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, '0, 1'b1, 1'b1, 0);
         if (last_rsp && !seen) begin
            chk("t2_rsp_lat", 64'(inst_valid_o), 64'd1);
            seen = 1'b1;
         end
      end
      chk("t2_count", 64'(n_cons >= 3), 64'd1);

      // decode stalled: buffer fills, fetch stops
      for (int i = 0; i < 30; i++)
         step(1'b0, '0, 1'b1, 1'b0, int'($urandom_range(0, 3)));
      chk("t3_req_idle", 64'(imem_req_valid_o), 64'd0);
      chk("t3_full", 64'(inst_valid_o), 64'd1);
      chk("t3_rsp_drained", 64'(q_addr.size()), 64'd0);
      chk("t3_fill", (fetch_ptr - exp_pc) >> 2, 64'd2);

      // redirect with nothing outstanding: request on the next cycle
      step(1'b1, 64'h8000_2000, 1'b0, 1'b0, 0);
      chk("redir_req_valid", 64'(imem_req_valid_o), 64'd1);
      chk("redir_addr", imem_req_addr_o, 64'h8000_2000);
      chk("redir_flush", 64'(inst_valid_o), 64'd0);

      // redirect while waiting: stale response dropped
      step(1'b0, '0, 1'b1, 1'b1, 3);
      chk("t4_accept", 64'(last_acc), 64'd1);
      step(1'b1, 64'h8000_1000, 1'b0, 1'b1, 0);
      run_until_cons("t4", 64'h8000_1000);

      // redirect coincident with rsp and a head pop
      for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0, 0);
      step(1'b1, 64'h8000_3000, 1'b0, 1'b0, 0);
      step(1'b0, '0, 1'b1, 1'b0, 0);
      step(1'b0, '0, 1'b1, 1'b0, 0);
      step(1'b0, '0, 1'b1, 1'b0, 0);
      step(1'b1, 64'h8000_4000, 1'b1, 1'b1, 0);
      chk("t5_flush", 64'(inst_valid_o), 64'd0);
      chk("t5_head_pc", last_cons_pc, 64'h8000_3000);
      run_until_cons("t5", 64'h8000_4000);

      // reset asserted while a response is outstanding
      last_acc = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!last_acc) step(1'b0, '0, 1'b1, 1'b1, 3);
      end
      rst = 1'b0;
      #1;
      chk_reset_outs("rst_mid");
      model_reset();
      imem_rsp_valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0, 0);
      chk("rst_mid_req", 64'(imem_req_valid_o), 64'd1);
      chk("rst_mid_raddr", imem_req_addr_o, RPC);

`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
      step(1'b1, 64'h8000_0002, 1'b0, 1'b0, 0);
      chk("mis_flag", 64'(exc_misalign_o), 64'd1);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 0);
      chk("mis_no_req", 64'(imem_req_valid_o), 64'd0);
      step(1'b1, 64'h8000_0100, 1'b0, 1'b0, 0);
      chk("mis_clear", 64'(exc_misalign_o), 64'd0);
      chk("mis_req", 64'(imem_req_valid_o), 64'd1);
      chk("mis_addr", imem_req_addr_o, 64'h8000_0100);
`endif

      // random traffic, including redirects across the 2^64 wrap
      for (int i = 0; i < 1500; i++) begin
         rd = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 9) == 0) tg = 64'hFFFF_FFFF_FFFF_FFF0;
         else tg = RPC + (64'($urandom_range(0, 4095)) << 2);
         tg = tg | (64'($urandom_range(0, 3)) & LOWMASK);
         step(rd, tg, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
              int'($urandom_range(0, 3)));
      end
      for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, 1'b1, 0);
      chk("progress", 64'(n_cons > 100), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
